pingpong_ram_ctrl: RTL

//  Parametrised ping-pong controller for two single-port-per-side banks (ram1/ram2) sitting between the map-data source and the map renderer.

---
 rtl/pingpong_ram_ctrl_if.sv | 25 ++
 rtl/pingpong_ram_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_ram_ctrl_if.sv
// Handshake bundle between the map-data source, the map renderer and the
// ping-pong controller. The controller takes the slave side.
interface pingpong_ram_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (
    output flush, wr_valid, wr_data, rd_req,
    input  wr_ready, rd_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_req,
    output wr_ready, rd_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong controller for two RAM banks: the writer fills one bank while the
// reader drains the other; banks swap once the writer has committed its bank
// and the reader has consumed everything in the other one.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | writer owns wr_bank and accepts words
// FULL  | write bank committed, waiting for the reader to drain
// SWAP  | one cycle: exchange banks, hand wlen to the reader
module pingpong_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              map,
  pingpong_ram_ctrl_if.slave bus,
  input  logic [DATA_W-1:0] ram1_read_data,
  input  logic [DATA_W-1:0] ram2_read_data,
  output logic              ram1_write_en,
  output logic              ram1_read_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [ADDR_W-1:0] ram1_read_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic              ram2_read_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [ADDR_W-1:0] ram2_read_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic              wr_bank,
  output logic              overflow,
  output logic [CNT_W-1:0]  swap_count
);

  // Pointers must be able to hold DEPTH itself, which may not fit in ADDR_W.
  localparam int PTR_W = $clog2(DEPTH + 1);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    SWAP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wlen_q, wlen_d;
  ptr_t              rlen_q, rlen_d;
  logic              wr_bank_q, wr_bank_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  swap_count_q, swap_count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              rd_bank_q, rd_bank_d;

  logic              wr_ready_s;
  logic              rd_ready_s;
  logic              wr_acc;
  logic              rd_acc;
  ptr_t              wr_ptr_inc;
  logic              fill_done;

  // Write pointer after this cycle's accepted word; a flush in the same
  // cycle commits that word too.
  assign wr_ptr_inc = wr_ptr_q + (wr_acc ? ONE : '0);
  assign fill_done  = map && (state_q == FILL) &&
                      ((wr_ptr_inc == DEPTH_P) || (bus.flush && (wr_ptr_inc != '0)));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= FILL;
    else         state_q <= state_d;
  end

  // Next-state logic; everything holds while map is low.
  always_comb begin
    state_d = state_q;
    if (map) begin
      case (state_q)
        FILL:    if (fill_done) state_d = FULL;
        FULL:    if (rd_ptr_q == rlen_q) state_d = SWAP;
        SWAP:    state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // Handshake and RAM strobe outputs.
  always_comb begin
    wr_ready_s = map && (state_q == FILL);
    rd_ready_s = map && (rd_ptr_q < rlen_q) && (state_q != SWAP);
    wr_acc     = wr_ready_s && bus.wr_valid;
    rd_acc     = rd_ready_s && bus.rd_req;

    ram1_write_en      = wr_acc && !wr_bank_q;
    ram2_write_en      = wr_acc && wr_bank_q;
    ram1_read_en       = rd_acc && wr_bank_q;
    ram2_read_en       = rd_acc && !wr_bank_q;
    ram1_write_address = ADDR_W'(wr_ptr_q);
    ram2_write_address = ADDR_W'(wr_ptr_q);
    ram1_read_address  = ADDR_W'(rd_ptr_q);
    ram2_read_address  = ADDR_W'(rd_ptr_q);
    ram1_write_data    = ram1_write_en ? bus.wr_data : '0;
    ram2_write_data    = ram2_write_en ? bus.wr_data : '0;
  end

  // Datapath next values: pointers, lengths, bank, counters, read pipeline.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wlen_d       = wlen_q;
    rlen_d       = rlen_q;
    wr_bank_d    = wr_bank_q;
    overflow_d   = overflow_q;
    swap_count_d = swap_count_q;
    // Read pipeline runs even with map low so an in-flight word still lands.
    rd_valid_d   = rd_acc;
    rd_last_d    = rd_acc && ((rd_ptr_q + ONE) == rlen_q);
    rd_bank_d    = rd_acc ? !wr_bank_q : rd_bank_q;

    if (map) begin
      if (bus.wr_valid && !wr_ready_s) overflow_d = 1'b1;
      if (state_q == FILL) wr_ptr_d = wr_ptr_inc;
      if (fill_done)       wlen_d   = wr_ptr_inc;
      if (rd_acc)          rd_ptr_d = rd_ptr_q + ONE;
      if (state_q == SWAP) begin
        wr_bank_d    = !wr_bank_q;
        rlen_d       = wlen_q;
        rd_ptr_d     = '0;
        wr_ptr_d     = '0;
        swap_count_d = swap_count_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wlen_q       <= '0;
      rlen_q       <= '0;
      wr_bank_q    <= 1'b0;
      overflow_q   <= 1'b0;
      swap_count_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wlen_q       <= wlen_d;
      rlen_q       <= rlen_d;
      wr_bank_q    <= wr_bank_d;
      overflow_q   <= overflow_d;
      swap_count_q <= swap_count_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_bank_q    <= rd_bank_d;
    end
  end

  // Read data comes from the bank latched at request time, zero when idle.
  assign bus.rd_data  = rd_valid_q ? (rd_bank_q ? ram2_read_data : ram1_read_data) : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_ready = rd_ready_s;
  assign wr_bank      = wr_bank_q;
  assign overflow     = overflow_q;
  assign swap_count   = swap_count_q;

endmodule
